// File: rtl/nios2_timer_pkg.sv
// Shared definitions for the interval-timer sequencer.
//   - s1 register map and control-register bit positions
//   - sequencer state encoding
//   - single-beat bus request struct and builders
package nios2_timer_pkg;

  // s1 register map (16-bit timer core)
  localparam logic [2:0] TM_STATUS  = 3'd0;
  localparam logic [2:0] TM_CONTROL = 3'd1;
  localparam logic [2:0] TM_PERL    = 3'd2;
  localparam logic [2:0] TM_PERH    = 3'd3;
  localparam logic [2:0] TM_SNAPL   = 3'd4;
  localparam logic [2:0] TM_SNAPH   = 3'd5;

  // control register bit positions
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_STAT  = 4'd1,
    ST_WR_PERL  = 4'd2,
    ST_WR_PERH  = 4'd3,
    ST_WR_CTRL  = 4'd4,
    ST_WAIT_IRQ = 4'd5,
    ST_CLR_STAT = 4'd6,
    ST_CLR_WAIT = 4'd7,
    ST_SNAP_WR  = 4'd8,
    ST_SNAP_RDL = 4'd9,
    ST_SNAP_RDH = 4'd10,
    ST_SNAP_CAP = 4'd11,
    ST_WR_STOP  = 4'd12,
    ST_DONE     = 4'd13
  } tc_state_t;

  // one bus beat: vld=0 means bus idle next cycle
  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } tm_req_t;

  function automatic tm_req_t tm_wr(input logic [2:0] a, input logic [15:0] d);
    tm_req_t r;
    r.vld  = 1'b1;
    r.wr   = 1'b1;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  function automatic tm_req_t tm_rd(input logic [2:0] a);
    tm_req_t r;
    r.vld  = 1'b1;
    r.wr   = 1'b0;
    r.addr = a;
    r.data = 16'h0;
    return r;
  endfunction

endpackage

// File: rtl/nios2_timer_bus_drv.sv
// Registered single-beat Avalon-MM master for the timer s1 port.
// A request presented in cycle N appears on the bus in cycle N+1 and lasts
// exactly one cycle. For reads, cap is high in the cycle the slave's
// readdata is valid (the cycle after the address), with cap_data beside it.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req             bus beat for the next cycle (vld=0 -> idle)
//   tm_*            timer s1 signals
//   cap, cap_data   read-data capture strobe and data
module nios2_timer_bus_drv
  import nios2_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  tm_req_t     req,
  output logic [2:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  input  logic [15:0] tm_readdata,
  output logic        cap,
  output logic [15:0] cap_data
);

  localparam int STAGES = 1;

  // [0]: read address on bus, [STAGES]: read data valid
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= 3'd0;
      tm_writedata  <= 16'h0;
      vld_pipe      <= '0;
    end else begin
      tm_chipselect <= req.vld;
      tm_write_n    <= ~(req.vld & req.wr);
      tm_address    <= req.vld ? req.addr : 3'd0;
      tm_writedata  <= (req.vld & req.wr) ? req.data : 16'h0;
      vld_pipe      <= {vld_pipe[STAGES-1:0], req.vld & ~req.wr};
    end
  end

  assign cap      = vld_pipe[STAGES];
  assign cap_data = tm_readdata;

endmodule

// File: rtl/nios2_system_timer_ctrl.sv
// Autonomous sequencer for the 16-bit interval timer. Takes a command
// (period in cycles, timeout count), programs the timer, clears status on
// every irq, and reports ticks / completion. Also serves counter snapshots
// and aborts.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/ready/period/count   command handshake (ready only in IDLE)
//   abort                          level, ends the run
//   snap_req / snap_valid/value    snapshot request and 32-bit result
//   tick, tick_count               per-timeout pulse and run count
//   done, err, busy                run end, rejected command, not-idle
//   tm_*                           timer s1 port
module nios2_system_timer_ctrl
  import nios2_timer_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] CTRL_RUN  = 4'h7,
  parameter logic [3:0] CTRL_STOP = 4'h8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_period,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  input  logic             snap_req,
  output logic             snap_valid,
  output logic [31:0]      snap_value,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [2:0]       tm_address,
  output logic             tm_chipselect,
  output logic             tm_write_n,
  output logic [15:0]      tm_writedata,
  input  logic [15:0]      tm_readdata,
  input  logic             tm_irq
);

  tc_state_t        state, state_nxt;
  logic [31:0]      per_m1;      // timer reloads P and counts through 0
  logic [CNT_W-1:0] run_n;
  logic             snap_pend;
  logic [15:0]      snap_lo;
  tm_req_t          req;
  logic             cap;
  logic [15:0]      cap_data;
  logic             accept, reject, snap_any, cnt_hit, snap_take;

  assign accept   = (state == ST_IDLE) && cmd_valid && (cmd_period != 32'd0);
  assign reject   = (state == ST_IDLE) && cmd_valid && (cmd_period == 32'd0);
  assign snap_any = snap_req | snap_pend;
  assign cnt_hit  = (run_n != '0) && (tick_count == run_n);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_WR_STAT;
      // period writes stop the timer, so control goes last
      ST_WR_STAT:  state_nxt = abort ? ST_WR_STOP : ST_WR_PERL;
      ST_WR_PERL:  state_nxt = abort ? ST_WR_STOP : ST_WR_PERH;
      ST_WR_PERH:  state_nxt = abort ? ST_WR_STOP : ST_WR_CTRL;
      ST_WR_CTRL:  state_nxt = abort ? ST_WR_STOP : ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        if (abort)         state_nxt = ST_WR_STOP;
        else if (tm_irq)   state_nxt = ST_CLR_STAT;
        else if (snap_any) state_nxt = ST_SNAP_WR;
      end
      ST_CLR_STAT: state_nxt = ST_CLR_WAIT;
      // irq is still high here from before the status write landed
      ST_CLR_WAIT: state_nxt = cnt_hit ? ST_WR_STOP : ST_WAIT_IRQ;
      ST_SNAP_WR:  state_nxt = ST_SNAP_RDL;
      ST_SNAP_RDL: state_nxt = ST_SNAP_RDH;
      ST_SNAP_RDH: state_nxt = ST_SNAP_CAP;
      ST_SNAP_CAP: state_nxt = ST_WAIT_IRQ;
      ST_WR_STOP:  state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  assign snap_take = (state == ST_WAIT_IRQ) && (state_nxt == ST_SNAP_WR);

  // bus beat is chosen for the state being entered so it is on the bus
  // during that state's cycle
  always_comb begin
    req = '0;
    case (state_nxt)
      ST_WR_STAT:  req = tm_wr(TM_STATUS, 16'h0);
      ST_WR_PERL:  req = tm_wr(TM_PERL, per_m1[15:0]);
      ST_WR_PERH:  req = tm_wr(TM_PERH, per_m1[31:16]);
      ST_WR_CTRL:  req = tm_wr(TM_CONTROL, {12'h0, CTRL_RUN});
      ST_CLR_STAT: req = tm_wr(TM_STATUS, 16'h0);
      ST_SNAP_WR:  req = tm_wr(TM_SNAPL, 16'h0);
      ST_SNAP_RDL: req = tm_rd(TM_SNAPL);
      ST_SNAP_RDH: req = tm_rd(TM_SNAPH);
      ST_WR_STOP:  req = tm_wr(TM_CONTROL, {12'h0, CTRL_STOP});
      default:     req = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      per_m1     <= 32'd0;
      run_n      <= '0;
      tick_count <= '0;
      snap_pend  <= 1'b0;
      snap_lo    <= 16'h0;
      snap_value <= 32'd0;
      snap_valid <= 1'b0;
      tick       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      tick      <= (state_nxt == ST_CLR_STAT);
      done      <= (state_nxt == ST_DONE);
      err       <= reject;

      if (accept) begin
        per_m1     <= cmd_period - 32'd1;
        run_n      <= cmd_count;
        tick_count <= '0;
      end else if ((state_nxt == ST_CLR_STAT) && (tick_count != '1)) begin
        tick_count <= tick_count + CNT_W'(1);
      end

      // requests seen outside WAIT_IRQ (or beaten by irq) wait here, merged
      snap_pend <= snap_any & ~snap_take;

      snap_valid <= 1'b0;
      if ((state == ST_SNAP_RDH) && cap) snap_lo <= cap_data;
      if ((state == ST_SNAP_CAP) && cap) begin
        snap_value <= {cap_data, snap_lo};
        snap_valid <= 1'b1;
      end
    end
  end

  nios2_timer_bus_drv u_bus (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .tm_address    (tm_address),
    .tm_chipselect (tm_chipselect),
    .tm_write_n    (tm_write_n),
    .tm_writedata  (tm_writedata),
    .tm_readdata   (tm_readdata),
    .cap           (cap),
    .cap_data      (cap_data)
  );

endmodule
